ibex_multdiv_ctrl: RTL and testbench
====================================

# ibex_multdiv_ctrl

Sequencing controller for the multi-cycle multiply/divide path of the execute block. It takes one M-extension operation per handshake and drives the EX block's multdiv enables, selects and operands. It owns the two 34-bit intermediate-value registers that the slow multdiv iterates on, holds the request until EX signals completion, and returns the registered result over a valid/ready response port. Optionally, it pads completion to a fixed latency.

## Interface
- `LAT_MAX`, default 37: fixed completion latency in cycles, counted from request accept, when padding is compiled in.
- `TIMEOUT`, default 63: watchdog limit in cycles; an operation not done by then is aborted with an error.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset. One clock; reset asserts asynchronously.
- `req_valid_i`  in  1  operation request.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `req_op_i`  in  2  operator: 00 MUL, 01 MULH, 10 DIV, 11 REM.
- `req_signed_i`  in  2  signed mode, `{b_signed, a_signed}`.
- `req_a_i`, `req_b_i`  in  32 each  operands.
- `kill_i`  in  1  flush the in-flight operation.
- `mult_en_o`, `div_en_o`, `mult_sel_o`, `div_sel_o`  out  1 each  EX control.
- `multdiv_operator_o`  out  2  to EX.
- `signed_mode_o`  out  2  to EX.
- `op_a_o`, `op_b_o`  out  32 each  operands held stable to EX.
- `multdiv_ready_id_o`  out  1  result may be consumed.
- `data_ind_timing_o`  out  1  to EX.
- `ex_valid_i`  in  1  EX completion.
- `result_ex_i`  in  32  EX result.
- `imd_val_we_i`  in  2  intermediate write enables.
- `imd_val_d_i`  in  68  intermediate values.
- `imd_val_q_o`  out  68  registered intermediates back to EX.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted.
- `rsp_result_o`  out  32  result.
- `rsp_err_o`  out  1  watchdog abort.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, PAD, RESP.
  - IDLE: `req_ready_o`=1. On `req_valid_i`, latch op, signed mode and operands; clear counter; go to EXEC.
  - EXEC: assert `mult_en_o` and `mult_sel_o` for op 0x/1x... precisely: ops 00/01 drive `mult_en_o` and `mult_sel_o`; ops 10/11 drive `div_en_o` and `div_sel_o`. `multdiv_ready_id_o`=1.
    - On `ex_valid_i`: capture `result_ex_i`, deassert enables, then go to PAD if padding is active and count < LAT_MAX, else RESP.
    - If count reaches TIMEOUT first: result := 0, err := 1, go to RESP.
  - PAD: enables low; wait until count == LAT_MAX, then go to RESP.
  - RESP: `rsp_valid_o`=1 with stable result and err. On `rsp_ready_i`, go to IDLE.
- Intermediate registers:
  - `imd_val_q_o[34*i +: 34]` loads `imd_val_d_i[34*i +: 34]` when `imd_val_we_i[i]`, in any state.
  - The registers are not cleared between operations.
- Counter: 6-bit, increments every non-IDLE cycle, saturates at 63.
- `kill_i` in EXEC or PAD: enables drop combinationally the same cycle; next state is IDLE; no response.
- `kill_i` in RESP: response dropped, go to IDLE. `kill_i` in IDLE is ignored.
- Simultaneous `ex_valid_i` and `kill_i`: kill wins.
- Simultaneous `ex_valid_i` and timeout: `ex_valid_i` wins.
- Division by zero and overflow: the EX result is passed through unmodified.

## Timing
- Reset values: all outputs 0, state IDLE, imd registers 0. Exception: `req_ready_o`=1.
- Request accepted in cycle 0 → enables high from cycle 1.
- `ex_valid_i` in cycle N → `rsp_valid_o` in cycle N+1 (no padding).
- Padding compiled in: `rsp_valid_o` rises in cycle LAT_MAX+1 whenever N ≤ LAT_MAX.
- Requests are accepted only in IDLE. Minimum spacing between requests is 3 cycles.
- Operand outputs are registered and do not change during EXEC.
- Reset asserted mid-operation: immediate return to reset values; any pending response is lost.

## Configuration
- `IBEX_MULTDIV_DIT_EN` defined: PAD state is present and `data_ind_timing_o`=1. Every non-killed, non-timeout operation completes at LAT_MAX+1 regardless of operand values.
- `IBEX_MULTDIV_DIT_EN` undefined: PAD state is removed, `data_ind_timing_o`=0, and the response follows `ex_valid_i` by one cycle.

## Test plan
- MUL 7×6, signed 00 → `rsp_result_o`=0x0000002A, `rsp_err_o`=0; `mult_en_o` high from cycle 1 until the cycle of `ex_valid_i`.
- DIV 0xFFFFFFF9 ÷ 2, signed 11 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIV 5 ÷ 0 → 0xFFFFFFFF, no error.
- `kill_i` in cycle 5 of a DIV → enables low that cycle, IDLE next cycle, no `rsp_valid_o`; the next MUL 3×3 returns 9.
- `rsp_ready_i` held low for 10 cycles → result and valid stable, `req_ready_o`=0 throughout.
- Macro defined, MULH 1×1 → `rsp_valid_o` exactly in cycle 38. `ex_valid_i` forced never → `rsp_err_o`=1 at cycle 64, result 0.

Source files
------------

// File: rtl/ibex_multdiv_ctrl.sv
// Sequencing controller for the multi-cycle multiply/divide path of the EX block.
// Define IBEX_MULTDIV_DIT_EN to pad every completed operation to LAT_MAX+1 cycles.
module ibex_multdiv_ctrl #(
   parameter int unsigned LAT_MAX = 37,
   parameter int unsigned TIMEOUT = 63
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_op_i,
   input  logic [1:0]  req_signed_i,
   input  logic [31:0] req_a_i,
   input  logic [31:0] req_b_i,
   input  logic        kill_i,
   output logic        mult_en_o,
   output logic        div_en_o,
   output logic        mult_sel_o,
   output logic        div_sel_o,
   output logic [1:0]  multdiv_operator_o,
   output logic [1:0]  signed_mode_o,
   output logic [31:0] op_a_o,
   output logic [31:0] op_b_o,
   output logic        multdiv_ready_id_o,
   output logic        data_ind_timing_o,
   input  logic        ex_valid_i,
   input  logic [31:0] result_ex_i,
   input  logic [1:0]  imd_val_we_i,
   input  logic [67:0] imd_val_d_i,
   output logic [67:0] imd_val_q_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic        rsp_err_o,
   output logic        busy_o
);

`ifdef IBEX_MULTDIV_DIT_EN
   localparam bit DitEn = 1'b1;
`else
   localparam bit DitEn = 1'b0;
`endif

   localparam logic [5:0] LatMax     = 6'(LAT_MAX);
   localparam logic [5:0] TimeoutCnt = 6'(TIMEOUT);
   localparam logic [5:0] CntSat     = 6'h3F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      PAD  = 2'd2,
      RESP = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  sgn_q, sgn_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;
   logic [67:0] imd_q;
   logic        in_exec;
   logic        is_div;

   // cnt_q equals the number of cycles elapsed since the accept cycle.
   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sgn_d    = sgn_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      err_d    = err_q;

      if (state_q != IDLE && cnt_q != CntSat) begin
         cnt_d = cnt_q + 6'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               op_d    = req_op_i;
               sgn_d   = req_signed_i;
               a_d     = req_a_i;
               b_d     = req_b_i;
               cnt_d   = 6'd1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (kill_i) begin
               state_d = IDLE;
            end else if (ex_valid_i) begin
               result_d = result_ex_i;
               err_d    = 1'b0;
               state_d  = (DitEn && (cnt_q < LatMax)) ? PAD : RESP;
            end else if (cnt_q >= TimeoutCnt) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         PAD: begin
            if (kill_i) begin
               state_d = IDLE;
            end else if (cnt_q >= LatMax) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (kill_i || rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         sgn_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sgn_q    <= sgn_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   // NOTE: the intermediates are individual flops, not a memory, so they take the reset too.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         imd_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (imd_val_we_i[i]) begin
               imd_q[34*i +: 34] <= imd_val_d_i[34*i +: 34];
            end
         end
      end
   end

   assign in_exec = (state_q == EXEC);
   assign is_div  = op_q[1];

   // Kill drops the enables in the same cycle; the selects follow the state only.
   assign mult_en_o          = in_exec & ~is_div & ~kill_i;
   assign div_en_o           = in_exec &  is_div & ~kill_i;
   assign mult_sel_o         = in_exec & ~is_div;
   assign div_sel_o          = in_exec &  is_div;
   assign multdiv_ready_id_o = in_exec;
   assign multdiv_operator_o = op_q;
   assign signed_mode_o      = sgn_q;
   assign op_a_o             = a_q;
   assign op_b_o             = b_q;
   assign data_ind_timing_o  = DitEn;
   assign imd_val_q_o        = imd_q;
   assign req_ready_o        = (state_q == IDLE);
   assign busy_o             = (state_q != IDLE);
   assign rsp_valid_o        = (state_q == RESP) & ~kill_i;
   assign rsp_result_o       = result_q;
   assign rsp_err_o          = err_q;

endmodule

// File: tb/tb_ibex_multdiv_ctrl.sv
// Self-checking bench for ibex_multdiv_ctrl: a transaction-level timing model plus
// an arithmetic EX stand-in, compared against the DUT on every negative clock edge.
module tb_ibex_multdiv_ctrl;

   localparam int LAT_MAX = 37;
   localparam int TIMEOUT = 63;

`ifdef IBEX_MULTDIV_DIT_EN
   localparam bit DIT = 1'b1;
`else
   localparam bit DIT = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_op_i;
   logic [1:0]  req_signed_i;
   logic [31:0] req_a_i;
   logic [31:0] req_b_i;
   logic        kill_i;
   logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
   logic [1:0]  multdiv_operator_o;
   logic [1:0]  signed_mode_o;
   logic [31:0] op_a_o, op_b_o;
   logic        multdiv_ready_id_o;
   logic        data_ind_timing_o;
   logic        ex_valid_i;
   logic [31:0] result_ex_i;
   logic [1:0]  imd_val_we_i;
   logic [67:0] imd_val_d_i;
   logic [67:0] imd_val_q_o;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic        rsp_err_o;
   logic        busy_o;

   ibex_multdiv_ctrl #(.LAT_MAX(LAT_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_signed_i(req_signed_i),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .kill_i(kill_i),
      .mult_en_o(mult_en_o), .div_en_o(div_en_o),
      .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
      .multdiv_operator_o(multdiv_operator_o), .signed_mode_o(signed_mode_o),
      .op_a_o(op_a_o), .op_b_o(op_b_o),
      .multdiv_ready_id_o(multdiv_ready_id_o), .data_ind_timing_o(data_ind_timing_o),
      .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
      .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i), .imd_val_q_o(imd_val_q_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic        exp_req_ready, exp_busy, exp_mult_en, exp_div_en;
   logic        exp_mult_sel, exp_div_sel, exp_ready_id, exp_rsp_valid, exp_err;
   logic [31:0] exp_result, exp_a, exp_b;
   logic [1:0]  exp_op, exp_sgn;
   bit          chk_rsp, chk_ops;
   logic [33:0] imd_slot [2];

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Intermediate slots: each slot takes its new value whenever its write enable is set.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         imd_slot[0] <= '0;
         imd_slot[1] <= '0;
      end else begin
         if (imd_val_we_i[0]) imd_slot[0] <= imd_val_d_i[33:0];
         if (imd_val_we_i[1]) imd_slot[1] <= imd_val_d_i[67:34];
      end
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         check("req_ready", 68'(req_ready_o), 68'(exp_req_ready));
         check("busy", 68'(busy_o), 68'(exp_busy));
         check("mult_en", 68'(mult_en_o), 68'(exp_mult_en));
         check("div_en", 68'(div_en_o), 68'(exp_div_en));
         check("mult_sel", 68'(mult_sel_o), 68'(exp_mult_sel));
         check("div_sel", 68'(div_sel_o), 68'(exp_div_sel));
         check("ready_id", 68'(multdiv_ready_id_o), 68'(exp_ready_id));
         check("dit", 68'(data_ind_timing_o), 68'(DIT));
         check("rsp_valid", 68'(rsp_valid_o), 68'(exp_rsp_valid));
         check("imd_q", imd_val_q_o, {imd_slot[1], imd_slot[0]});
         if (chk_rsp) begin
            check("rsp_result", 68'(rsp_result_o), 68'(exp_result));
            check("rsp_err", 68'(rsp_err_o), 68'(exp_err));
         end
         if (chk_ops) begin
            check("operator", 68'(multdiv_operator_o), 68'(exp_op));
            check("signed_mode", 68'(signed_mode_o), 68'(exp_sgn));
            check("op_a", 68'(op_a_o), 68'(exp_a));
            check("op_b", 68'(op_b_o), 68'(exp_b));
         end
      end
   end

   // Arithmetic stand-in for the EX block (RISC-V M semantics).
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] sg,
                                              input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] a33, b33;
      logic signed [65:0] p;
      logic               sd;
      a33 = {sg[0] & a[31], a};
      b33 = {sg[1] & b[31], b};
      p   = a33 * b33;
      sd  = &sg;
      case (op)
         2'd0: return p[31:0];
         2'd1: return p[63:32];
         2'd2: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (!sd) return a / b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'($signed(a) / $signed(b));
         end
         default: begin
            if (b == 32'h0) return a;
            if (!sd) return a % b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
      endcase
   endfunction

   task automatic set_idle_exp();
      exp_req_ready = 1'b1; exp_busy = 1'b0;
      exp_mult_en = 1'b0; exp_div_en = 1'b0; exp_mult_sel = 1'b0; exp_div_sel = 1'b0;
      exp_ready_id = 1'b0; exp_rsp_valid = 1'b0;
      chk_rsp = 1'b0; chk_ops = 1'b0;
   endtask

   task automatic set_reset_exp();
      set_idle_exp();
      chk_rsp = 1'b1; exp_result = '0; exp_err = 1'b0;
      chk_ops = 1'b1; exp_op = '0; exp_sgn = '0; exp_a = '0; exp_b = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
      imd_val_we_i = 2'($urandom_range(0, 3));
      imd_val_d_i  = {4'($urandom), $urandom, $urandom};
   endtask

   task automatic idle_cycle();
      next_cycle();
      rst_ni       = 1'b1;
      req_valid_i  = 1'b0;
      req_op_i     = 2'($urandom_range(0, 3));
      req_a_i      = $urandom;
      kill_i       = 1'($urandom_range(0, 1));
      ex_valid_i   = 1'($urandom_range(0, 1));
      result_ex_i  = $urandom;
      rsp_ready_i  = 1'($urandom_range(0, 1));
      set_idle_exp();
   endtask

   // One transaction. ex_lat: cycle of ex_valid (outside 1..TIMEOUT = never);
   // kill_at / rst_at: cycle of kill or reset (0 = none); rsp_wait: cycles rsp_ready stays low.
   task automatic run_op(input logic [1:0] op, input logic [1:0] sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input int ex_lat, input int kill_at, input int rsp_wait,
                         input int rst_at, input bit use_lit, input logic [31:0] lit);
      bit          to;
      int          d, r, h, e;
      logic [31:0] ex_res, res;
      logic        kn, in_exec;
      to = (ex_lat < 1) || (ex_lat > TIMEOUT);
      d  = to ? TIMEOUT : ex_lat;
      r  = d + 1;
      if (!to && DIT && r < LAT_MAX + 1) r = LAT_MAX + 1;
      h  = r + rsp_wait;
      e  = h;
      if (kill_at >= 1 && kill_at <= e) e = kill_at;
      if (rst_at >= 1 && rst_at <= e) e = rst_at;
      ex_res = ref_result(op, sg, a, b);
      res    = to ? 32'h0 : (use_lit ? lit : ex_res);

      next_cycle();
      rst_ni = 1'b1;
      req_valid_i = 1'b1; req_op_i = op; req_signed_i = sg; req_a_i = a; req_b_i = b;
      kill_i = 1'($urandom_range(0, 1));
      ex_valid_i = 1'($urandom_range(0, 1));
      result_ex_i = $urandom;
      rsp_ready_i = 1'($urandom_range(0, 1));
      set_idle_exp();

      for (int k = 1; k <= e; k++) begin
         next_cycle();
         req_valid_i  = 1'($urandom_range(0, 1));
         req_op_i     = 2'($urandom_range(0, 3));
         req_signed_i = 2'($urandom_range(0, 3));
         req_a_i      = $urandom;
         req_b_i      = $urandom;
         kn           = (k == kill_at);
         kill_i       = kn;
         in_exec      = (k <= d);
         ex_valid_i   = in_exec ? (!to && k == ex_lat) : 1'($urandom_range(0, 1));
         result_ex_i  = (k == ex_lat) ? ex_res : $urandom;
         rsp_ready_i  = (k < r) ? 1'($urandom_range(0, 1)) : (k >= h);
         if (k == rst_at) begin
            rst_ni = 1'b0;
            set_reset_exp();
         end else begin
            exp_req_ready = 1'b0;
            exp_busy      = 1'b1;
            exp_mult_sel  = in_exec & ~op[1];
            exp_div_sel   = in_exec &  op[1];
            exp_mult_en   = exp_mult_sel & ~kn;
            exp_div_en    = exp_div_sel & ~kn;
            exp_ready_id  = in_exec;
            exp_rsp_valid = (k >= r) && !kn;
            chk_rsp       = exp_rsp_valid;
            exp_result    = res;
            exp_err       = to;
            chk_ops       = 1'b1;
            exp_op = op; exp_sgn = sg; exp_a = a; exp_b = b;
         end
      end
      idle_cycle();
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [1:0]  op, sg;
      int          sel, ex_lat, kill_at, rst_at;
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_op_i = '0; req_signed_i = '0; req_a_i = '0; req_b_i = '0;
      kill_i = 1'b0; ex_valid_i = 1'b0; result_ex_i = '0; rsp_ready_i = 1'b0;
      imd_val_we_i = '0; imd_val_d_i = '0;
      set_reset_exp();
      chk_en = 1'b1;
      @(negedge clk_i);
      next_cycle();
      set_reset_exp();
      idle_cycle();

      // Directed cases with hand-computed results.
      run_op(2'd0, 2'b00, 32'd7, 32'd6, 4, 0, 0, 0, 1'b1, 32'h0000_002A);
      run_op(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 10, 0, 1, 0, 1'b1, 32'hFFFF_FFFD);
      run_op(2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 12, 0, 0, 0, 1'b1, 32'hFFFF_FFFF);
      run_op(2'd2, 2'b00, 32'd5, 32'd0, 6, 0, 0, 0, 1'b1, 32'hFFFF_FFFF);
      run_op(2'd2, 2'b11, 32'd100, 32'd7, 20, 5, 0, 0, 1'b1, 32'd14);
      run_op(2'd0, 2'b00, 32'd3, 32'd3, 3, 0, 0, 0, 1'b1, 32'd9);
      run_op(2'd0, 2'b00, 32'd2, 32'd21, 5, 0, 10, 0, 1'b1, 32'h0000_002A);
      run_op(2'd1, 2'b11, 32'd1, 32'd1, 3, 0, 0, 0, 1'b1, 32'h0);
      run_op(2'd0, 2'b00, 32'd4, 32'd4, 0, 0, 2, 0, 1'b1, 32'h0);
      run_op(2'd0, 2'b00, 32'd5, 32'd5, 63, 0, 0, 0, 1'b1, 32'd25);
      run_op(2'd3, 2'b00, 32'd17, 32'd5, 2, 45, 50, 0, 1'b1, 32'd2);
      run_op(2'd0, 2'b00, 32'd6, 32'd6, 7, 7, 0, 0, 1'b1, 32'd36);
      run_op(2'd1, 2'b01, 32'hFFFF_FFFF, 32'd2, 9, 0, 0, 6, 1'b1, 32'hFFFF_FFFF);
      run_op(2'd0, 2'b00, 32'd8, 32'd8, 2, 20, 30, 0, 1'b1, 32'd64);

      for (int i = 0; i < 150; i++) begin
         op = 2'($urandom_range(0, 3));
         sg = op[1] ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 19);
         ex_lat = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(60, 70) : $urandom_range(1, 40);
         kill_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 45) : 0;
         rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 20) : 0;
         run_op(op, sg, pick_operand(), pick_operand(), ex_lat, kill_at,
                $urandom_range(0, 4), rst_at, 1'b0, 32'h0);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      idle_cycle();
      @(negedge clk_i);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
